// File: rtl/data_memory_bytelane_if.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane_if
// Request/response bundle between the load/store issue logic and the
// byte-lane data memory.
//   req_valid/req_ready : request handshake (accept = valid & ready at clk edge)
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I width/sign code
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data, 0 for stores and faults (held)
//   rsp_fault           : access rejected (held)
// -----------------------------------------------------------------------------
interface data_memory_bytelane_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane
// RV32I data memory with byte/half/word loads and stores, sign/zero extension,
// fault detection, fixed-latency response and a post-reset clear sweep.
// Ports:
//   i_clk        : clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   bus          : data_memory_bytelane_if.slave request/response bundle
//   o_init_done  : 1 once the clear sweep has finished
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing word[r_clr_idx], one word per cycle
// S_IDLE  | ready to accept a request
// S_BUSY  | request accepted, counting down to the response cycle
// -----------------------------------------------------------------------------
module data_memory_bytelane #(
    parameter int DEPTH_WORDS    = 256,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    data_memory_bytelane_if.slave  bus,
    output logic                   o_init_done
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_clr_idx;
    logic [2:0]    r_count;
    logic          r_init_done;
    logic [31:0]   r_pend_rdata, r_rsp_rdata;
    logic          r_pend_fault, r_rsp_fault;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept, w_in_range, w_legal, w_aligned, w_fault, w_store;
    logic          w_load_rsp;
    logic [AW-1:0] w_word_idx;
    logic [31:0]   w_rd_word, w_ext, w_lane_data, w_rsp_now;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;

    assign w_accept   = bus.req_valid & bus.req_ready;
    assign w_word_idx = bus.req_addr[AW+1:2];
    assign w_in_range = ({2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_rd_word  = r_mem[w_word_idx];
    assign w_byte     = w_rd_word[8*bus.req_addr[1:0] +: 8];
    assign w_half     = bus.req_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    // Decode width/sign, lane enables and alignment from funct3.
    always_comb begin
        w_legal     = 1'b0;
        w_aligned   = 1'b1;
        w_be        = 4'b0000;
        w_lane_data = 32'h0;
        w_ext       = 32'h0;
        case (bus.req_funct3)
            3'b000: begin
                w_legal     = 1'b1;
                w_be        = 4'b0001 << bus.req_addr[1:0];
                w_lane_data = {4{bus.req_wdata[7:0]}};
                w_ext       = {{24{w_byte[7]}}, w_byte};
            end
            3'b001: begin
                w_legal     = 1'b1;
                w_aligned   = ~bus.req_addr[0];
                w_be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{bus.req_wdata[15:0]}};
                w_ext       = {{16{w_half[15]}}, w_half};
            end
            3'b010: begin
                w_legal     = 1'b1;
                w_aligned   = (bus.req_addr[1:0] == 2'b00);
                w_be        = 4'b1111;
                w_lane_data = bus.req_wdata;
                w_ext       = w_rd_word;
            end
            3'b100: begin
                w_legal = ~bus.req_we;
                w_ext   = {24'h0, w_byte};
            end
            3'b101: begin
                w_legal   = ~bus.req_we;
                w_aligned = ~bus.req_addr[0];
                w_ext     = {16'h0, w_half};
            end
            default: ;
        endcase
    end

    assign w_fault   = ~w_legal | ~w_aligned | ~w_in_range;
    assign w_store   = w_accept & bus.req_we & ~w_fault;
    assign w_rsp_now = (w_fault | bus.req_we) ? 32'h0 : w_ext;

    // Output registers load on the edge that opens the response cycle:
    // the accept edge itself when READ_LAT is 1, otherwise when count hits 1.
    assign w_load_rsp = (w_accept && (READ_LAT == 1)) ||
                        ((r_state == S_BUSY) && (r_count == 3'd1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == AW'(DEPTH_WORDS - 1)) w_next = S_IDLE;
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY:  if (r_count == 3'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_clr_idx    <= '0;
            r_count      <= 3'd0;
            r_init_done  <= 1'b0;
            r_pend_rdata <= 32'h0;
            r_pend_fault <= 1'b0;
            r_rsp_rdata  <= 32'h0;
            r_rsp_fault  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_init_done <= r_init_done | (w_next == S_IDLE);
            if (r_state == S_CLEAR)
                r_clr_idx <= r_clr_idx + 1'b1;
            if (w_accept) begin
                r_count      <= 3'(READ_LAT - 1);
                r_pend_rdata <= w_rsp_now;
                r_pend_fault <= w_fault;
            end else if ((r_state == S_BUSY) && (r_count != 3'd0)) begin
                r_count <= r_count - 1'b1;
            end
            if (w_load_rsp) begin
                r_rsp_rdata <= (r_state == S_IDLE) ? w_rsp_now : r_pend_rdata;
                r_rsp_fault <= (r_state == S_IDLE) ? w_fault   : r_pend_fault;
            end
        end
    end

    // Storage has no reset; the sweep provides the zero state.
    always_ff @(posedge i_clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= 32'h0;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_word_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) & r_init_done;
    assign bus.rsp_valid = (r_state == S_BUSY) & (r_count == 3'd0);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
    assign o_init_done   = r_init_done;
endmodule

// File: tb/tb_data_memory_bytelane.sv
module tb_data_memory_bytelane;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    logic init1, init2, init3;
    int   n_err = 0;
    int   n_chk = 0;
    int   cnt;
    logic seenv;

    always #5 clk = ~clk;

    data_memory_bytelane_if bus1 ();
    data_memory_bytelane_if bus2 ();
    data_memory_bytelane_if bus3 ();

    data_memory_bytelane #(.DEPTH_WORDS(256), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1), .o_init_done(init1));
    data_memory_bytelane #(.DEPTH_WORDS(16), .READ_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .bus(bus2), .o_init_done(init2));
    data_memory_bytelane #(.DEPTH_WORDS(16), .READ_LAT(3), .CLEAR_ON_RESET(1)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus3), .o_init_done(init3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus(virtual data_memory_bytelane_if vif);
        vif.req_valid  = 1'b0;
        vif.req_we     = 1'b0;
        vif.req_funct3 = 3'b010;
        vif.req_addr   = 32'h0;
        vif.req_wdata  = 32'h0;
    endtask

    // One transaction: wait for ready, present for one edge, await the pulse.
    task automatic access(virtual data_memory_bytelane_if vif, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_flt, input string tag);
        int   waits;
        logic seen;
        @(negedge clk);
        waits = 0;
        while (!vif.req_ready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, "_ready"}, 32'(vif.req_ready), 32'd1);
        vif.req_valid  = 1'b1;
        vif.req_we     = we;
        vif.req_funct3 = f3;
        vif.req_addr   = a;
        vif.req_wdata  = wd;
        @(posedge clk);
        #1 vif.req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (vif.rsp_valid) seen = 1'b1;
        end
        chk({tag, "_rsp"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_rdata"}, vif.rsp_rdata, exp_rd);
            chk({tag, "_fault"}, 32'(vif.rsp_fault), 32'(exp_flt));
        end
    endtask

    initial begin
        idle_bus(bus1);
        idle_bus(bus2);
        idle_bus(bus3);

        // T1: reset state and clear sweep length
        #1;
        chk("rst_ready", 32'(bus1.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("rst_rdata", bus1.rsp_rdata, 32'h0);
        chk("rst_fault", 32'(bus1.rsp_fault), 32'd0);
        chk("rst_init_done", 32'(init1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        cnt = 0;
        while (!bus1.req_ready && cnt < 1000) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("clear_cycles", 32'(cnt), 32'd256);
        chk("init_done", 32'(init1), 32'd1);
        access(bus1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, 1'b0, "t1_lw_10");
        access(bus1, 1'b0, 3'b010, 32'h0000_03FC, 32'h0, 32'h0, 1'b0, "t1_lw_3fc");

        // T2: sign/zero extension of every lane
        access(bus1, 1'b1, 3'b010, 32'h8, 32'h8081_7F01, 32'h0, 1'b0, "t2_sw");
        access(bus1, 1'b0, 3'b000, 32'h8, 32'h0, 32'h0000_0001, 1'b0, "t2_lb_8");
        access(bus1, 1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFF_FF80, 1'b0, "t2_lb_b");
        access(bus1, 1'b0, 3'b100, 32'hB, 32'h0, 32'h0000_0080, 1'b0, "t2_lbu_b");
        access(bus1, 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFF_8081, 1'b0, "t2_lh_a");
        access(bus1, 1'b0, 3'b101, 32'h8, 32'h0, 32'h0000_7F01, 1'b0, "t2_lhu_8");

        // T3: partial stores preserve the other lanes
        access(bus1, 1'b1, 3'b010, 32'h8, 32'h1122_3344, 32'h0, 1'b0, "t3_sw");
        access(bus1, 1'b1, 3'b000, 32'h9, 32'hDEAD_BEAA, 32'h0, 1'b0, "t3_sb");
        access(bus1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h1122_AA44, 1'b0, "t3_lw1");
        access(bus1, 1'b1, 3'b001, 32'hA, 32'h1234_BEEF, 32'h0, 1'b0, "t3_sh");
        access(bus1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, "t3_lw2");
        access(bus1, 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FFAA, 1'b0, "t3_lb_9");
        access(bus1, 1'b0, 3'b101, 32'hA, 32'h0, 32'h0000_BEEF, 1'b0, "t3_lhu_a");

        // T4: faults, no memory change, held fault outputs
        access(bus1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, "t4_lw_6");
        access(bus1, 1'b1, 3'b001, 32'h3, 32'h0000_FFFF, 32'h0, 1'b1, "t4_sh_3");
        access(bus1, 1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 1'b1, "t4_f011");
        access(bus1, 1'b1, 3'b100, 32'h8, 32'h0, 32'h0, 1'b1, "t4_sbu");
        access(bus1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, "t4_lw_400");
        @(negedge clk);
        chk("t4_fault_hold", 32'(bus1.rsp_fault), 32'd1);
        access(bus1, 1'b0, 3'b010, 32'h8, 32'h0, 32'hBEEF_AA44, 1'b0, "t4_unchanged");
        access(bus1, 1'b1, 3'b010, 32'h3FC, 32'hA5A5_5A5A, 32'h0, 1'b0, "t4_sw_last");
        access(bus1, 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hA5A5_5A5A, 1'b0, "t4_lw_last");
        @(negedge clk);
        chk("t4_rdata_hold", bus1.rsp_rdata, 32'hA5A5_5A5A);
        chk("t4_valid_pulse", 32'(bus1.rsp_valid), 32'd0);

        // T5: READ_LAT=3 with req_valid held -> one accept per 4 cycles
        access(bus3, 1'b1, 3'b010, 32'h4, 32'hCAFE_F00D, 32'h0, 1'b0, "t5_sw");
        @(negedge clk);
        cnt = 0;
        while (!bus3.req_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        bus3.req_valid  = 1'b1;
        bus3.req_we     = 1'b0;
        bus3.req_funct3 = 3'b010;
        bus3.req_addr   = 32'h4;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_ready_%0d", i), 32'(bus3.req_ready), 32'((i % 4) == 0));
            chk($sformatf("t5_valid_%0d", i), 32'(bus3.rsp_valid), 32'((i % 4) == 3));
            if ((i % 4) == 3)
                chk($sformatf("t5_rdata_%0d", i), bus3.rsp_rdata, 32'hCAFE_F00D);
            @(negedge clk);
        end
        bus3.req_valid = 1'b0;

        // T6: reset in the middle of BUSY (READ_LAT=2)
        access(bus2, 1'b1, 3'b010, 32'h4, 32'h1234_5678, 32'h0, 1'b0, "t6_sw");
        access(bus2, 1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_5678, 1'b0, "t6_lw");
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_we     = 1'b0;
        bus2.req_funct3 = 3'b010;
        bus2.req_addr   = 32'h4;
        @(posedge clk);
        #1 bus2.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(bus2.req_ready), 32'd0);
        rst2_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(bus2.req_ready), 32'd0);
        chk("t6_rst_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("t6_rst_rdata", bus2.rsp_rdata, 32'h0);
        chk("t6_rst_fault", 32'(bus2.rsp_fault), 32'd0);
        chk("t6_rst_init", 32'(init2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst2_n = 1'b1;
        cnt = 0;
        seenv = 1'b0;
        while (!bus2.req_ready && cnt < 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            seenv = seenv | bus2.rsp_valid;
        end
        chk("t6_clear_cycles", 32'(cnt), 32'd16);
        chk("t6_no_rsp", 32'(seenv), 32'd0);
        access(bus2, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0, 1'b0, "t6_rezeroed");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
